// File: rtl/mole_gen_if.sv
// Game-side signal bundle of the whack-a-mole generator.
// The generator connects through the slave modport; the player/judge side uses master.
interface mole_gen_if;
    logic       start;
    logic [1:0] level;
    logic       hit;
    logic [7:0] led;
    logic       EN;
    logic [5:0] hit_cnt;
    logic [5:0] miss_cnt;
    logic       done;

    modport master (
        output start, level, hit,
        input  led, EN, hit_cnt, miss_cnt, done
    );

    modport slave (
        input  start, level, hit,
        output led, EN, hit_cnt, miss_cnt, done
    );
endinterface

// File: rtl/mole_gen.sv
// Whack-a-mole generator: shows one LED at a time, separated by blank gaps.
// Each mole ends on a hit or on timeout, and the hits and misses of a game are counted.
module mole_gen #(
    parameter int TICK_DIV  = 16,
    parameter int ROUNDS    = 32,
    parameter int GAP_TICKS = 2
) (
    input  logic      clk,
    input  logic      rst,
    mole_gen_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GAP  = 2'd1;
    localparam logic [1:0] SHOW = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [15:0] PRESC_LAST  = 16'(TICK_DIV - 1);
    localparam logic [3:0]  GAP_LAST    = 4'(GAP_TICKS - 1);
    localparam logic [5:0]  ROUND_TOTAL = 6'(ROUNDS);
    localparam logic [5:0]  CNT_MAX     = 6'd63;

    logic [1:0]  state;
    logic [15:0] presc;
    logic [3:0]  tick_cnt;
    logic [3:0]  show_last;
    logic [5:0]  round;
    logic [7:0]  lfsr;
    logic [2:0]  prev_pos;
    logic        have_prev;

    logic [7:0]  led;
    logic        en;
    logic [5:0]  hit_cnt;
    logic [5:0]  miss_cnt;
    logic        done;

    logic        tick_end;
    logic        gap_end;
    logic        show_end;
    logic        mole_end;
    logic        last_round;
    logic [2:0]  pos;
    logic [7:0]  lfsr_next;
    logic [5:0]  round_next;

    // Final tick index of a show, i.e. show ticks minus one.
    function automatic logic [3:0] show_last_for(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 4'd7;
            2'd1:    return 4'd5;
            2'd2:    return 4'd3;
            default: return 4'd1;
        endcase
    endfunction

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        tick_end   = (presc == PRESC_LAST);
        gap_end    = tick_end && (tick_cnt == GAP_LAST);
        show_end   = tick_end && (tick_cnt == show_last);
        mole_end   = bus.hit || show_end;
        round_next = round + 6'd1;
        last_round = (round_next == ROUND_TOTAL);
        pos        = lfsr[2:0];
        if (have_prev && (pos == prev_pos))
            pos = pos + 3'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            tick_cnt  <= '0;
            show_last <= 4'd7;
            round     <= '0;
            lfsr      <= 8'hA5;
            prev_pos  <= '0;
            have_prev <= 1'b0;
            led       <= 8'h00;
            en        <= 1'b1;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state     <= GAP;
                        presc     <= '0;
                        tick_cnt  <= '0;
                        round     <= '0;
                        hit_cnt   <= '0;
                        miss_cnt  <= '0;
                        have_prev <= 1'b0;
                        done      <= 1'b0;
                    end
                end

                GAP: begin
                    if (gap_end) begin
                        state     <= SHOW;
                        presc     <= '0;
                        tick_cnt  <= '0;
                        led       <= 8'd1 << pos;
                        en        <= 1'b0;
                        prev_pos  <= pos;
                        have_prev <= 1'b1;
                        show_last <= show_last_for(bus.level);
                    end else if (tick_end) begin
                        presc    <= '0;
                        tick_cnt <= tick_cnt + 4'd1;
                    end else begin
                        presc <= presc + 16'd1;
                    end
                end

                SHOW: begin
                    if (mole_end) begin
                        // A hit on the expiry cycle still counts as a hit.
                        if (bus.hit) begin
                            if (hit_cnt != CNT_MAX)
                                hit_cnt <= hit_cnt + 6'd1;
                        end else if (miss_cnt != CNT_MAX) begin
                            miss_cnt <= miss_cnt + 6'd1;
                        end
                        round    <= round_next;
                        led      <= 8'h00;
                        en       <= 1'b1;
                        presc    <= '0;
                        tick_cnt <= '0;
                        state    <= last_round ? DONE : GAP;
                        done     <= last_round;
                    end else if (tick_end) begin
                        presc    <= '0;
                        tick_cnt <= tick_cnt + 4'd1;
                    end else begin
                        presc <= presc + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led      = led;
    assign bus.EN       = en;
    assign bus.hit_cnt  = hit_cnt;
    assign bus.miss_cnt = miss_cnt;
    assign bus.done     = done;

endmodule

// File: tb/tb_mole_gen.sv
// Self-checking bench for mole_gen: table-driven mole scenarios on a 4-round instance,
// plus randomized 63-round games and a reset-during-show sequence.
module tb_mole_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mole_gen_if ifa ();
    mole_gen_if ifb ();

    mole_gen #(.TICK_DIV(16), .ROUNDS(4), .GAP_TICKS(2)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    mole_gen #(.TICK_DIV(2), .ROUNDS(63), .GAP_TICKS(1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Reference LFSR; both instances share the reset, so both follow this sequence.
    logic [7:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 8'hA5;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] level;
        int         hit_at;
        bit         gap_hit;
        int         exp_show;
        bit         exp_hit;
    } vec_t;

    vec_t       vecs [16];
    logic [2:0] prev_pos_a;
    bit         have_prev_a;

    task automatic start_a();
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start   = 1'b0;
        have_prev_a = 1'b0;
    endtask

    // Entered at a negedge in a GAP cycle; returns at the first negedge after the mole.
    task automatic run_mole(input vec_t v, input string tag, input int exp_hits, input int exp_misses);
        int         gap;
        int         show;
        logic [7:0] lf;
        logic [2:0] p;
        bit         ok_en;
        bit         ok_oh;
        gap   = 0;
        show  = 0;
        ok_en = 1'b1;
        ok_oh = 1'b1;
        lf    = lfsr_m;
        ifa.level = v.level;
        while (ifa.led == 8'h00 && gap < 2000) begin
            if (ifa.EN !== 1'b1) ok_en = 1'b0;
            ifa.hit = v.gap_hit;
            lf = lfsr_m;
            gap++;
            @(negedge clk);
        end
        ifa.hit = 1'b0;
        p = lf[2:0];
        if (have_prev_a && p == prev_pos_a) p = p + 3'd1;
        check({tag, "_gap_len"}, gap, 32);
        check({tag, "_position"}, int'(ifa.led), int'(8'd1 << p));
        prev_pos_a  = p;
        have_prev_a = 1'b1;
        while (ifa.led != 8'h00 && show < 2000) begin
            if (ifa.EN !== 1'b0) ok_en = 1'b0;
            if (!$onehot(ifa.led)) ok_oh = 1'b0;
            ifa.hit = (show == v.hit_at);
            if (show == 1) ifa.level = ~v.level;
            show++;
            @(negedge clk);
        end
        ifa.hit = 1'b0;
        check({tag, "_show_len"}, show, v.exp_show);
        check({tag, "_en_phase"}, int'(ok_en), 1);
        check({tag, "_onehot"}, int'(ok_oh), 1);
        check({tag, "_hit_cnt"}, int'(ifa.hit_cnt), exp_hits);
        check({tag, "_miss_cnt"}, int'(ifa.miss_cnt), exp_misses);
    endtask

    task automatic run_game_b(input int g);
        int         cyc;
        int         mh;
        int         mm;
        int         bad_oh;
        int         bad_en;
        int         bad_pos;
        int         bad_rep;
        logic [7:0] led_now;
        logic [7:0] led_prev;
        logic [7:0] last_mole;
        logic [7:0] lf_prev;
        logic [2:0] p;
        logic [2:0] prev_p;
        bit         have_p;
        bit         hit_prev;
        bit         hit_now;
        string      tag;
        tag = $sformatf("b%0d", g);
        cyc = 0; mh = 0; mm = 0;
        bad_oh = 0; bad_en = 0; bad_pos = 0; bad_rep = 0;
        led_prev = 8'h00; last_mole = 8'h00; lf_prev = lfsr_m;
        prev_p = 3'd0; have_p = 1'b0; hit_prev = 1'b0;
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        check({tag, "_start_hit_cnt"}, int'(ifb.hit_cnt), 0);
        check({tag, "_start_miss_cnt"}, int'(ifb.miss_cnt), 0);
        check({tag, "_start_done"}, int'(ifb.done), 0);
        while (cyc < 5000) begin
            led_now = ifb.led;
            if (led_now != 8'h00 && !$onehot(led_now)) bad_oh++;
            if (ifb.EN !== (led_now == 8'h00)) bad_en++;
            if (led_prev == 8'h00 && led_now != 8'h00) begin
                p = lf_prev[2:0];
                if (have_p && p == prev_p) p = p + 3'd1;
                if (led_now != (8'd1 << p)) bad_pos++;
                if (have_p && led_now == last_mole) bad_rep++;
                prev_p    = p;
                have_p    = 1'b1;
                last_mole = led_now;
            end
            if (led_prev != 8'h00 && led_now == 8'h00) begin
                if (hit_prev) mh++;
                else          mm++;
            end
            if (ifb.done) break;
            hit_now   = ($urandom_range(3) == 0);
            ifb.hit   = hit_now;
            ifb.level = 2'($urandom_range(3));
            hit_prev  = hit_now;
            led_prev  = led_now;
            lf_prev   = lfsr_m;
            @(negedge clk);
            cyc++;
        end
        ifb.hit = 1'b0;
        check({tag, "_done"}, int'(ifb.done), 1);
        check({tag, "_hit_cnt"}, int'(ifb.hit_cnt), mh);
        check({tag, "_miss_cnt"}, int'(ifb.miss_cnt), mm);
        check({tag, "_moles"}, mh + mm, 63);
        check({tag, "_onehot_errs"}, bad_oh, 0);
        check({tag, "_en_errs"}, bad_en, 0);
        check({tag, "_pos_errs"}, bad_pos, 0);
        check({tag, "_repeat_errs"}, bad_rep, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   eh;
        int   em;
        int   k;
        vec_t v;

        vecs[0] = '{2'd3, -1,  1'b0, 32,  1'b0};
        vecs[1] = '{2'd0,  5,  1'b1, 6,   1'b1};
        vecs[2] = '{2'd2,  63, 1'b0, 64,  1'b1};
        vecs[3] = '{2'd1, -1,  1'b0, 96,  1'b0};
        vecs[4] = '{2'd0, -1,  1'b1, 128, 1'b0};
        vecs[5] = '{2'd2, -1,  1'b0, 64,  1'b0};
        vecs[6] = '{2'd1,  0,  1'b0, 1,   1'b1};
        vecs[7] = '{2'd3,  31, 1'b0, 32,  1'b1};
        for (int i = 8; i < 12; i++)  vecs[i] = '{2'd3, -1, 1'b0, 32, 1'b0};
        for (int i = 12; i < 16; i++) vecs[i] = '{2'd0,  5, 1'b0, 6,  1'b1};

        ifa.start = 1'b0; ifa.level = 2'd0; ifa.hit = 1'b0;
        ifb.start = 1'b0; ifb.level = 2'd0; ifb.hit = 1'b0;
        have_prev_a = 1'b0;
        prev_pos_a  = 3'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #11;
        check("reset_led", int'(ifa.led), 0);
        check("reset_en", int'(ifa.EN), 1);
        check("reset_done", int'(ifa.done), 0);
        check("reset_hit_cnt", int'(ifa.hit_cnt), 0);
        check("reset_miss_cnt", int'(ifa.miss_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int g = 0; g < 2; g++) run_game_b(g);

        check("a_idle_led", int'(ifa.led), 0);
        check("a_idle_en", int'(ifa.EN), 1);
        check("a_idle_done", int'(ifa.done), 0);

        for (int g = 0; g < 4; g++) begin
            start_a();
            check($sformatf("a%0d_start_hit_cnt", g), int'(ifa.hit_cnt), 0);
            check($sformatf("a%0d_start_miss_cnt", g), int'(ifa.miss_cnt), 0);
            check($sformatf("a%0d_start_done", g), int'(ifa.done), 0);
            eh = 0;
            em = 0;
            for (int r = 0; r < 4; r++) begin
                k = g * 4 + r;
                v = vecs[k];
                if (v.exp_hit) eh++;
                else           em++;
                run_mole(v, $sformatf("row%0d", k), eh, em);
            end
            check($sformatf("a%0d_done", g), int'(ifa.done), 1);
            check($sformatf("a%0d_done_led", g), int'(ifa.led), 0);
            check($sformatf("a%0d_done_en", g), int'(ifa.EN), 1);
            ifa.hit = 1'b1;
            repeat (3) @(negedge clk);
            ifa.hit = 1'b0;
            check($sformatf("a%0d_hold_hit_cnt", g), int'(ifa.hit_cnt), eh);
            check($sformatf("a%0d_hold_miss_cnt", g), int'(ifa.miss_cnt), em);
            check($sformatf("a%0d_hold_done", g), int'(ifa.done), 1);
        end

        // Reset between clock edges in the middle of a show.
        start_a();
        ifa.level = 2'd0;
        k = 0;
        while (ifa.led == 8'h00 && k < 200) begin
            k++;
            @(negedge clk);
        end
        check("rst_show_reached", int'(ifa.led != 8'h00), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_async_led", int'(ifa.led), 0);
        check("rst_async_en", int'(ifa.EN), 1);
        check("rst_async_done", int'(ifa.done), 0);
        check("rst_async_hit_cnt", int'(ifa.hit_cnt), 0);
        check("rst_async_miss_cnt", int'(ifa.miss_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_idle_led", int'(ifa.led), 0);
        check("rst_idle_en", int'(ifa.EN), 1);
        check("rst_idle_done", int'(ifa.done), 0);

        start_a();
        v = '{2'd0, 2, 1'b0, 3, 1'b1};
        run_mole(v, "post_rst", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
